ring_buffer_flow: RTL
=====================

Name: ring_buffer_flow

Overview:
- Parametrised successor to the team's 8-bit ring buffer: a single-clock circular FIFO with configurable data width and depth.
- Adds simultaneous read/write in one cycle, a write acknowledge, occupancy count, almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Sits between producer and consumer pipeline stages of the Phaethon core and peripherals, replacing ad-hoc debug outputs with defined status.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_BITS, 3, log2 of depth; DEPTH = 2**ADDR_BITS entries, all usable.
- AFULL_LEVEL, DEPTH-1, almostFull asserts when count >= AFULL_LEVEL; legal range 1..DEPTH.
- AEMPTY_LEVEL, 1, almostEmpty asserts when count <= AEMPTY_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- flush  in  1  synchronous discard of all contents.
- writeEnable  in  1  write request this cycle.
- dataWrite  in  DATA_WIDTH  write data.
- dataWriteAck  out  1  one-cycle pulse: the previous cycle's write was stored.
- readEnable  in  1  read request this cycle.
- dataReadAck  out  1  one-cycle pulse: dataRead holds valid popped data.
- dataRead  out  DATA_WIDTH  popped data; registered.
- count  out  ADDR_BITS+1  current occupancy, 0..DEPTH.
- full, empty, almostFull, almostEmpty  out  1 each  status, decoded from registered count.
- overflow  out  1  sticky: a write was dropped because the buffer was full.
- underflow  out  1  sticky: a read was refused because the buffer was empty.
- clearErrors  in  1  clears overflow and underflow.

Behaviour:
- Reset (reset==0 at an edge): pointers=0, count=0, dataRead=0, both acks=0, overflow=0, underflow=0. Resulting status: empty=1, full=0, almostEmpty=1, almostFull=(AFULL_LEVEL==0 ? 1 : 0).
- Priority at each edge: reset > flush > read/write.
- Flush: pointers=0, count=0, acks=0. dataRead holds its value and error flags hold. Any read/write requested in the same cycle is ignored and sets no flags.
- Read accept = readEnable && count!=0.
  - On accept: dataRead <= mem[rdPtr], rdPtr increments with wrap at DEPTH, dataReadAck=1 in the next cycle. Latency is 1 cycle.
  - On refuse: dataReadAck=0, dataRead holds, underflow set.
- Write accept = writeEnable && (count!=DEPTH || read accepted this cycle).
  - On accept: mem[wrPtr] <= dataWrite, wrPtr increments with wrap, dataWriteAck=1 in the next cycle.
  - On refuse: the data is discarded, dataWriteAck=0, overflow set, and contents are unchanged.
- Simultaneous read and write:
  - Full: both accepted; count unchanged; the read returns the oldest entry.
  - Empty: no bypass; the write is accepted, the read is refused (underflow set), and count becomes 1.
  - Otherwise: both accepted; count unchanged.
- count update: +1 on write only, -1 on read only, unchanged on both or neither. Never exceeds DEPTH and never wraps below 0.
- Pointers are ADDR_BITS wide and wrap modulo DEPTH. full/empty come from count, never from pointer compare.
- Acks are high for exactly one cycle per accepted operation. Back-to-back accepts hold them high continuously.
- clearErrors clears both sticky flags. An error event in the same cycle wins, so the flag stays 1.
- Unwritten memory content is don't-care; it is never observable through dataRead.

Test Plan:
(All use DATA_WIDTH=8, ADDR_BITS=2, AFULL_LEVEL=3, AEMPTY_LEVEL=1.)
- Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles -> dataWriteAck high 4 cycles; count 1,2,3,4; almostFull at count 3; full at 4. A fifth write of 0x55 -> no ack, overflow=1, count stays 4.
- From full, read 4 times -> dataReadAck high 4 cycles; dataRead 0x11,0x22,0x33,0x44; empty=1 after. A fifth read -> no ack, underflow=1, dataRead stays 0x44.
- Wrap-around: write 3 entries, read 2, write 3 more (0xA0..0xA2) -> the read sequence continues in order across the pointer wrap; count peaks at 4.
- Simultaneous: at full, assert writeEnable (0x66) and readEnable -> both acks, count stays 4, 0x66 is popped last. At empty, assert both -> write ack only, underflow=1, count=1.
- Flush with count=3 and writeEnable=1 in the same cycle -> count=0, empty=1, no write ack, overflow unchanged. clearErrors together with an overflow-causing write -> overflow remains 1.
- Reset mid-operation: assert reset=0 for one edge while count=2 and read/write active -> next cycle count=0, acks=0, dataRead=0, flags=0.

Source files
------------

// File: rtl/ring_buffer_flow.sv
// ---------------------------------------------------------------------------
// ring_buffer_flow
//   Single-clock circular FIFO with configurable width/depth, one-cycle
//   registered read, write/read acknowledges, occupancy count, almost-full /
//   almost-empty thresholds, synchronous flush and sticky error flags.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        synchronous, active-low reset
//   flush        synchronous discard of all contents (beats read/write)
//   writeEnable  write request; dataWrite is the word to store
//   dataWriteAck one-cycle pulse: the previous cycle's write was stored
//   readEnable   read request
//   dataReadAck  one-cycle pulse: dataRead holds freshly popped data
//   dataRead     registered popped data (holds between pops)
//   count        occupancy 0..DEPTH
//   full/empty/almostFull/almostEmpty  status decoded from count
//   overflow     sticky: a write was dropped because the buffer was full
//   underflow    sticky: a read was refused because the buffer was empty
//   clearErrors  clears overflow/underflow (a same-cycle error wins)
// ---------------------------------------------------------------------------
module ring_buffer_flow #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_BITS    = 3,
  parameter int AFULL_LEVEL  = (1 << ADDR_BITS) - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  writeEnable,
  input  logic [DATA_WIDTH-1:0] dataWrite,
  output logic                  dataWriteAck,
  input  logic                  readEnable,
  output logic                  dataReadAck,
  output logic [DATA_WIDTH-1:0] dataRead,
  output logic [ADDR_BITS:0]    count,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clearErrors
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_CNT  = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AFULL_CNT  = (ADDR_BITS + 1)'(AFULL_LEVEL);
  localparam logic [ADDR_BITS:0] AEMPTY_CNT = (ADDR_BITS + 1)'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_BITS-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_BITS:0]   count_reg, count_next;
  logic                 write_ack_reg, write_ack_next;
  logic                 read_ack_reg, read_ack_next;
  logic                 overflow_reg, overflow_next;
  logic                 underflow_reg, underflow_next;
  logic [DATA_WIDTH-1:0] data_read_reg;

  logic rd_accept;
  logic wr_accept;

  // A full buffer still takes a write when a read frees a slot in the same
  // cycle. An empty buffer never bypasses: the read is refused.
  assign rd_accept = readEnable && (count_reg != '0);
  assign wr_accept = writeEnable && ((count_reg != DEPTH_CNT) || rd_accept);

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    write_ack_next = 1'b0;
    read_ack_next  = 1'b0;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (flush) begin
      // Requests in a flush cycle are ignored entirely; error flags hold.
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (rd_accept) begin
        rd_ptr_next   = rd_ptr_reg + 1'b1;
        read_ack_next = 1'b1;
      end
      if (wr_accept) begin
        wr_ptr_next    = wr_ptr_reg + 1'b1;
        write_ack_next = 1'b1;
      end

      unique case ({wr_accept, rd_accept})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase

      // Clear first so that an error event in the same cycle wins.
      if (clearErrors) begin
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
      end
      if (writeEnable && !wr_accept) overflow_next  = 1'b1;
      if (readEnable && !rd_accept)  underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      write_ack_reg <= 1'b0;
      read_ack_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      write_ack_reg <= write_ack_next;
      read_ack_reg  <= read_ack_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage array: no reset so it maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (reset && !flush && wr_accept) begin
      mem[wr_ptr_reg] <= dataWrite;
    end
  end

  // Registered read port; holds its value across flush and refused reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_read_reg <= '0;
    end else if (!flush && rd_accept) begin
      data_read_reg <= mem[rd_ptr_reg];
    end
  end

  assign dataWriteAck = write_ack_reg;
  assign dataReadAck  = read_ack_reg;
  assign dataRead     = data_read_reg;
  assign count        = count_reg;
  assign full         = (count_reg == DEPTH_CNT);
  assign empty        = (count_reg == '0);
  assign almostFull   = (count_reg >= AFULL_CNT);
  assign almostEmpty  = (count_reg <= AEMPTY_CNT);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule
